// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the word-addressed memory controller.
// LINE_WORDS is also used by the cache management unit.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACK  = 2'd2
  } state_t;

  localparam int LINE_WORDS        = 4;
  localparam int DEF_READ_LATENCY  = 4;
  localparam int DEF_WRITE_LATENCY = 2;
  localparam int DEF_BURST_LATENCY = 1;
  localparam int CNT_W             = $clog2(DEF_READ_LATENCY) + 1;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Countdown width for an arbitrary latency set; never narrower than the default build.
  function automatic int cnt_width(input int rd_lat, input int wr_lat, input int bu_lat);
    int w;
    w = $clog2(max3(rd_lat, wr_lat, bu_lat)) + 1;
    return (w > CNT_W) ? w : CNT_W;
  endfunction

  // True when cur is the next word of the same line as prev.
  function automatic logic line_next(input logic [31:0] prev, input logic [31:0] cur);
    return (cur == prev + 32'd1) && ((cur % LINE_WORDS) != 0);
  endfunction

endpackage

// File: rtl/mem_array.sv
// Single-port synchronous RAM, one write enable, registered read port.
// Contents are never cleared; they survive controller reset.
module mem_array #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/mem_ctrl.sv
// Main-memory controller: one single-word access per cs handshake with fixed latency.
// Optional MEM_CTRL_BURST_EN shortens sequential in-line accesses to BURST_LATENCY.
//
// state  | meaning
// S_IDLE | ready; capture request when cs=1
// S_WAIT | latency countdown; array access when count reaches 0
// S_ACK  | one-cycle ack, dout valid for reads
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int MEM_WORDS_WIDTH = 10,
  parameter int READ_LATENCY    = DEF_READ_LATENCY,
  parameter int WRITE_LATENCY   = DEF_WRITE_LATENCY,
  parameter int BURST_LATENCY   = DEF_BURST_LATENCY
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cs,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        ack
);

  localparam int W  = MEM_WORDS_WIDTH;
  localparam int CW = cnt_width(READ_LATENCY, WRITE_LATENCY, BURST_LATENCY);
  localparam logic [CW-1:0] RD_LOAD = CW'(READ_LATENCY - 1);
  localparam logic [CW-1:0] WR_LOAD = CW'(WRITE_LATENCY - 1);

  state_t         state, state_nxt;
  logic [CW-1:0]  cnt, cnt_nxt, load_val;
  logic           we_q;
  logic [W-1:0]   idx_q, idx_in;
  logic [31:0]    din_q, rd_data;
  logic           capture, access;
  logic           unused_addr;

  // Upper address bits wrap modulo depth; byte-offset bits are don't-care.
  assign idx_in      = addr[W+1:2];
  assign unused_addr = ^{addr[31:W+2], addr[1:0]};

`ifdef MEM_CTRL_BURST_EN
  localparam logic [CW-1:0] BU_LOAD = CW'(BURST_LATENCY - 1);
  logic seq_ok, seq_hit;

  // seq_ok marks the single IDLE cycle right after ACK; idx_q still holds the previous index.
  always_ff @(posedge clk) begin
    if (!rst) seq_ok <= 1'b0;
    else      seq_ok <= (state == S_ACK);
  end

  assign seq_hit  = seq_ok && (we == we_q) && line_next(32'(idx_q), 32'(idx_in));
  assign load_val = seq_hit ? BU_LOAD : (we ? WR_LOAD : RD_LOAD);
`else
  assign load_val = we ? WR_LOAD : RD_LOAD;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      we_q  <= 1'b0;
      idx_q <= '0;
      din_q <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (capture) begin
        we_q  <= we;
        idx_q <= idx_in;
        din_q <= din;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    capture   = 1'b0;
    access    = 1'b0;
    ack       = 1'b0;
    case (state)
      S_IDLE: begin
        if (cs) begin
          capture   = 1'b1;
          cnt_nxt   = load_val;
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt == '0) begin
          access    = 1'b1;
          state_nxt = S_ACK;
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      S_ACK: begin
        ack       = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Gating with rst makes reset win over a coincident commit edge.
  mem_array #(.ADDR_W(W)) u_mem_array (
    .clk   (clk),
    .we    (access & we_q & rst),
    .re    (access & ~we_q & rst),
    .addr  (idx_q),
    .wdata (din_q),
    .rdata (rd_data)
  );

  assign dout = (state == S_ACK && !we_q) ? rd_data : 32'd0;

endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Word-addressed main-memory controller sitting directly downstream of the cache management unit on its RAM port. It accepts one single-word read or write per `cs` handshake, models a fixed access latency with a countdown, and returns a one-cycle `ack` with read data. It provides the per-word acknowledge that drives the cache unit's write-back and line-fill bursts of four words per 16-byte line.

## Interface
- `MEM_WORDS_WIDTH`, default 10: log2 of memory depth in 32-bit words; 1024 words.
- `READ_LATENCY`, default 4: cycles from request capture to read `ack`; must be ≥1.
- `WRITE_LATENCY`, default 2: cycles from request capture to write `ack`; must be ≥1.
- `BURST_LATENCY`, default 1: latency for sequential in-line accesses when `MEM_CTRL_BURST_EN` is defined; must be ≥1.

- `clk`  input  1  clock; all state changes on the rising edge.
- `rst`  input  1  synchronous, active-low reset; `0` means reset.
- `cs`  input  1  request valid.
- `we`  input  1  `1` selects write, `0` selects read; sampled together with `cs`.
- `addr`  input  32  byte address; bits `[1:0]` are ignored.
- `din`  input  32  write data.
- `dout`  output  32  read data; valid only while `ack`=1.
- `ack`  output  1  one-cycle completion pulse.

## Operation
- FSM states:
  - **IDLE**: `ack`=0. If `cs`=1, latch `we`, word index `addr[MEM_WORDS_WIDTH+1:2]` and `din`. Load the countdown with latency−1 and go to WAIT.
  - **WAIT**: decrement the count. At count 0, perform the array access and go to ACK.
    - Write: commit `din` on this edge.
    - Read: launch the array read.
  - **ACK**: `ack`=1. `dout` holds read data, or 0 for writes. Always go to IDLE the next cycle.
- Address bits above `MEM_WORDS_WIDTH+1` are ignored, so addresses wrap modulo depth. No error is signalled.
- The request is latched once captured. Dropping `cs` or changing `addr`, `din` or `we` during WAIT or ACK has no effect; the access completes and `ack` still pulses.
- Back-to-back requests: a new request is captured only in IDLE, i.e. the cycle after ACK. Holding `cs` high across a burst with the address changing after each `ack` yields sequential word accesses.
- The memory is not cleared by reset; array contents persist. The simulation initial value is 0.

## Timing
- Reset (`rst`=0 at an edge): state becomes IDLE, count 0, `ack`=0, `dout`=0. An in-flight write whose commit edge has not yet occurred is discarded.
- Reset has priority over any simultaneous commit edge.
- Request captured at edge E0 with latency L: the commit or read edge is E(L), `ack` is high for the cycle after E(L), and the controller is back in IDLE after E(L+1).
- Full word turnaround is L+2 cycles. A read with L=4 and `cs` held takes 6 cycles per word.
- `dout` is registered: it is 0 outside ACK and stable throughout the ACK cycle.
- The upstream unit samples on the falling edge, so `ack` and `dout` are stable for its half-cycle setup.

## Configuration
- `MEM_CTRL_BURST_EN` defined:
  - Condition: the request captured in the IDLE cycle immediately following ACK has the same `we`, and its word index equals the previous index + 1 without crossing a 4-word line boundary (`index[1:0]`≠0).
  - Effect: that request uses `BURST_LATENCY` instead of `READ_LATENCY`/`WRITE_LATENCY`.
  - A one-bit `seq_ok` register and the previous index are added.
- `MEM_CTRL_BURST_EN` undefined: every access uses its full latency and no sequence tracking logic is present.

## Structure
- Package `mem_ctrl_pkg` holds:
  - state enum (`S_IDLE`, `S_WAIT`, `S_ACK`)
  - countdown width constant `$clog2` of the maximum latency, plus one
  - line-words constant `LINE_WORDS=4`, shared with the cache unit
- Sub-module `mem_array`: single-port synchronous RAM with depth `2**MEM_WORDS_WIDTH`, one write-enable, registered read. The FSM stays in `mem_ctrl`.

## Test plan
- Reset with `rst`=0 for 3 cycles while `cs`=1 → `ack`=0 and `dout`=0 throughout; the first capture happens on the first edge with `rst`=1.
- Write 0xDEADBEEF to 0x100, then read 0x100, defaults → write `ack` 3 cycles after capture; read `ack` 5 cycles after capture with `dout`=0xDEADBEEF.
- 4-word line fill at 0x40–0x4C with `cs` held and address advanced on each `ack` → four `ack` pulses, 6 cycles apart, with the data previously written; with `MEM_CTRL_BURST_EN`, the 2nd–4th pulses come 3 cycles apart.
- Write 0x1 to 0x0, then read 0x1000 (depth wrap at 1024 words) → `dout`=0x1.
- Capture a write of 0x55 to 0x200, deassert `rst` low one cycle before the commit edge, then read 0x200 → old value returned; 0x55 was never written.
- Capture a read, then drop `cs` and change `addr` during WAIT → `ack` still pulses with data from the originally captured address.
